// File: rtl/kypd_pkg.sv
// Shared types, constants and bit-counting helpers for the keypad scanner.
package kypd_pkg;

   typedef enum logic [1:0] {
      DRIVE   = 2'd0,
      SAMPLE  = 2'd1,
      ADVANCE = 2'd2
   } scan_state_t;

   localparam int NUM_COLS = 4;
   localparam int NUM_ROWS = 4;

   // Key code for snapshot bit {col,row}: bit 4*col + row.
   localparam logic [3:0] KEY_MAP [16] = '{
      4'h1, 4'h4, 4'h7, 4'h0,
      4'h2, 4'h5, 4'h8, 4'hF,
      4'h3, 4'h6, 4'h9, 4'hE,
      4'hA, 4'hB, 4'hC, 4'hD
   };

   // Number of pressed keys in a 16-bit snapshot.
   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] n;
      n = '0;
      for (int i = 0; i < 16; i++) begin
         n = n + {4'd0, v[i]};
      end
      return n;
   endfunction

   // Bit position of the set bit; meaningful only when exactly one bit is set.
   function automatic logic [3:0] onehot_idx16(input logic [15:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < 16; i++) begin
         if (v[i]) idx = 4'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/kypd_scan_ctrl_if.sv
// Key event handshake between the scanner (master) and the game logic (slave).
interface kypd_scan_ctrl_if;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_ready;

   modport master (output key_code, output key_valid, input key_ready);
   modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/kypd_event_fifo.sv
// Small show-ahead event FIFO; a push into a full FIFO with no pop is dropped and flagged.
module kypd_event_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic             o_drop
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_full;
   logic             w_pop_ok;
   logic             w_push_ok;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   // A pop on an empty FIFO is ignored; a pop on a full FIFO frees the slot for a same-cycle push.
   assign w_pop_ok  = i_pop && !o_empty;
   assign w_push_ok = i_push && (!w_full || w_pop_ok);
   assign o_drop    = i_push && !w_push_ok;
   // Head is forced to zero while empty so the output is clean after reset.
   assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

   // Storage write; contents need no reset because the pointers qualify them.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   // Read/write pointer update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end
endmodule

// File: rtl/kypd_scan_ctrl.sv
// PmodKYPD column scanner: strobes columns, samples rows, debounces full scans
// and emits one key event per clean single-key press into an event FIFO.
module kypd_scan_ctrl
   import kypd_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 100000,
   parameter int DEBOUNCE_SCANS = 3,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_ROWS-1:0]    row,
   output logic [NUM_COLS-1:0]    col,
   kypd_scan_ctrl_if.master       key_if,
   input  logic                   clr_ovf,
   output logic                   overflow
);
   localparam int               CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [3:0]       DB_MAX   = 4'(DEBOUNCE_SCANS);
   localparam int               CIW      = $clog2(NUM_COLS);

   logic [NUM_ROWS-1:0] r_row_meta;
   logic [NUM_ROWS-1:0] r_row_sync;
   scan_state_t         r_state;
   scan_state_t         w_state_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [CIW-1:0]      r_col_idx;
   logic [CIW-1:0]      w_col_idx_next;
   logic [NUM_COLS-1:0] r_col;
   logic [15:0]         r_snap;
   logic [15:0]         r_prev;
   logic [15:0]         r_stable;
   logic [3:0]          r_db_cnt;
   logic [3:0]          w_db_cnt_next;
   logic                r_pressed;
   logic                r_overflow;
   logic                w_snap_done;
   logic                w_match;
   logic                w_update;
   logic                w_push;
   logic [3:0]          w_push_code;
   logic                w_fifo_empty;
   logic                w_drop;

   assign col            = r_col;
   assign overflow       = r_overflow;
   assign w_col_idx_next = r_col_idx + 1'b1;

   // Two-flop synchroniser; rows idle high so reset to all ones (no key).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_row_meta <= '1;
         r_row_sync <= '1;
      end else begin
         r_row_meta <= row;
         r_row_sync <= r_row_meta;
      end
   end

   // Scan state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= DRIVE;
      else        r_state <= w_state_next;
   end

   // Scan next-state: settle in DRIVE, then one SAMPLE and one ADVANCE cycle.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         DRIVE:   if (r_cnt == CNT_LAST) w_state_next = SAMPLE;
         SAMPLE:  w_state_next = ADVANCE;
         ADVANCE: w_state_next = DRIVE;
         default: w_state_next = DRIVE;
      endcase
   end

   // Settle counter, column drive and per-column snapshot capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt     <= '0;
         r_col_idx <= '0;
         r_col     <= 4'b1110;
         r_snap    <= '0;
      end else begin
         if (r_state == DRIVE && r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
         else                                       r_cnt <= '0;
         if (r_state == SAMPLE) r_snap[{r_col_idx, 2'b00} +: 4] <= ~r_row_sync;
         if (r_state == ADVANCE) begin
            r_col_idx <= w_col_idx_next;
            r_col     <= ~(4'b0001 << w_col_idx_next);
         end
      end
   end

   // A full scan completes on the ADVANCE out of the last column.
   assign w_snap_done   = (r_state == ADVANCE) && (r_col_idx == CIW'(NUM_COLS - 1));
   assign w_match       = (r_snap == r_prev);
   assign w_db_cnt_next = !w_match ? 4'd1 : ((r_db_cnt >= DB_MAX) ? DB_MAX : r_db_cnt + 4'd1);
   // Stable state is taken only when the run of identical scans first hits the threshold.
   assign w_update      = w_snap_done && (w_db_cnt_next == DB_MAX) && (!w_match || r_db_cnt != DB_MAX);
   // Emit only on none -> single key while released; multi-key states never emit.
   assign w_push        = w_update && (popcount16(r_snap) == 5'd1) && (r_stable == '0) && !r_pressed;
   assign w_push_code   = KEY_MAP[onehot_idx16(r_snap)];

   // Debounce history, stable state and press latch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev    <= '0;
         r_db_cnt  <= '0;
         r_stable  <= '0;
         r_pressed <= 1'b0;
      end else if (w_snap_done) begin
         r_prev   <= r_snap;
         r_db_cnt <= w_db_cnt_next;
         if (w_update) begin
            r_stable  <= r_snap;
            r_pressed <= (r_snap != '0);
         end
      end
   end

   // Sticky overflow; a drop wins over a same-cycle clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       r_overflow <= 1'b0;
      else if (w_drop)  r_overflow <= 1'b1;
      else if (clr_ovf) r_overflow <= 1'b0;
   end

   kypd_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (4)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_push_code),
      .i_pop   (key_if.key_ready),
      .o_data  (key_if.key_code),
      .o_empty (w_fifo_empty),
      .o_drop  (w_drop)
   );

   assign key_if.key_valid = ~w_fifo_empty;
endmodule

// File: tb/tb_kypd_scan_ctrl.sv
// Bench for kypd_scan_ctrl: keypad model driven from the column outputs, scan-level
// reference model of debounce / event / FIFO rules, randomized press sequences.
module tb_kypd_scan_ctrl;
   localparam int S     = 8;
   localparam int DEB   = 3;
   localparam int DEPTH = 4;
   localparam logic [3:0] TB_MAP [16] = '{
      4'h1, 4'h4, 4'h7, 4'h0, 4'h2, 4'h5, 4'h8, 4'hF,
      4'h3, 4'h6, 4'h9, 4'hE, 4'hA, 4'hB, 4'hC, 4'hD
   };

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  row;
   logic [3:0]  col;
   logic        clr_ovf = 1'b0;
   logic        overflow;
   logic [15:0] r_mask = '0;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state (scan granularity).
   logic [15:0] m_last;
   int          m_run;
   logic [15:0] m_stable;
   bit          m_pressed;
   bit          m_ovf;
   logic [3:0]  exp_q [$];

   kypd_scan_ctrl_if kif ();

   kypd_scan_ctrl #(
      .SETTLE_CYCLES  (S),
      .DEBOUNCE_SCANS (DEB),
      .FIFO_DEPTH     (DEPTH)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .row      (row),
      .col      (col),
      .key_if   (kif.master),
      .clr_ovf  (clr_ovf),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Keypad matrix: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      row = 4'hF;
      for (int k = 0; k < 4; k++) begin
         if (!col[k]) row = row & ~r_mask[4*k +: 4];
      end
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_last = '0; m_run = 0; m_stable = '0; m_pressed = 0; m_ovf = 0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; r_mask = '0; clr_ovf = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Wait for the negedge where col has just wrapped 0111 -> 1110 (end of a scan).
   task automatic wait_boundary();
      logic [3:0] prev;
      bit found;
      prev = col; found = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (prev == 4'b0111 && col == 4'b1110) begin found = 1; break; end
         prev = col;
      end
      if (!found) chk("scan_timeout", 16'd0, 16'd1);
   endtask

   // Hold one key mask for a whole scan, update the model, compare at the scan boundary.
   task automatic run_scan(input logic [15:0] mask);
      int idx;
      r_mask = mask;
      wait_boundary();
      if (m_run > 0 && mask == m_last) m_run++;
      else                             m_run = 1;
      m_last = mask;
      if (m_run == DEB) begin
         if ($countones(mask) == 1 && m_stable == 0 && !m_pressed) begin
            idx = 0;
            for (int i = 0; i < 16; i++) if (mask[i]) idx = i;
            if (exp_q.size() < DEPTH) exp_q.push_back(TB_MAP[idx]);
            else                      m_ovf = 1;
         end
         m_pressed = (mask != 0);
         m_stable  = mask;
      end
      if (kif.key_ready) begin
         if (exp_q.size() > 0) begin
            chk("evt_valid", 16'(kif.key_valid), 16'd1);
            chk("evt_code", 16'(kif.key_code), 16'(exp_q.pop_front()));
         end else begin
            chk("idle_valid", 16'(kif.key_valid), 16'd0);
         end
      end else begin
         chk("held_valid", 16'(kif.key_valid), 16'(exp_q.size() > 0));
         if (exp_q.size() > 0) chk("held_code", 16'(kif.key_code), 16'(exp_q[0]));
      end
      chk("ovf", 16'(overflow), 16'(m_ovf));
      $display("scan mask=%04h valid=%0b code=%0h ovf=%0b", mask, kif.key_valid, kif.key_code, overflow);
   endtask

   task automatic press(input int idx, input int hold, input int rel);
      for (int i = 0; i < hold; i++) run_scan(16'(1) << idx);
      for (int i = 0; i < rel; i++)  run_scan(16'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] cur;
      int         run, seg, kind, idx, idx2, n;
      int         picks [$];
      kif.key_ready = 1'b1;
      model_reset();

      // Reset state.
      @(negedge clk);
      chk("rst_col", 16'(col), 16'hE);
      chk("rst_valid", 16'(kif.key_valid), 16'd0);
      chk("rst_code", 16'(kif.key_code), 16'd0);
      chk("rst_ovf", 16'(overflow), 16'd0);
      $display("reset col=%b valid=%0b", col, kif.key_valid);

      // Idle scan: column rotation and hold time.
      do_reset();
      cur = col; run = 0; seg = 0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (col != cur) begin
            if (seg > 0) chk("col_hold", 16'(run), 16'd10);
            chk("col_next", 16'(col), 16'({cur[2:0], cur[3]}));
            chk("idle_nokey", 16'(kif.key_valid), 16'd0);
            $display("col %b -> %b after %0d", cur, col, run);
            cur = col; run = 1; seg++;
         end else begin
            run++;
         end
      end

      // Key 3, bounced key 5, ghosting pair then D.
      do_reset();
      kif.key_ready = 1'b1;
      press(8, 5, 4);
      run_scan(16'h0020); run_scan(16'h0020); run_scan(16'h0000);
      press(5, 4, 4);
      for (int i = 0; i < 4; i++) run_scan(16'h0011);
      for (int i = 0; i < 4; i++) run_scan(16'h0000);
      press(15, 4, 4);

      // Randomized press sequences.
      for (int it = 0; it < 10; it++) begin
         kind = $urandom_range(0, 2);
         idx  = $urandom_range(0, 15);
         idx2 = (idx + $urandom_range(1, 15)) % 16;
         case (kind)
            0: for (int i = 0; i < $urandom_range(1, 5); i++) run_scan(16'(1) << idx);
            1: for (int i = 0; i < $urandom_range(1, 4); i++) run_scan((16'(1) << idx) | (16'(1) << idx2));
            default: begin
               for (int i = 0; i < 3; i++) run_scan(16'(1) << idx);
               for (int i = 0; i < 3; i++) run_scan((16'(1) << idx) | (16'(1) << idx2));
               for (int i = 0; i < 3; i++) run_scan(16'(1) << idx);
            end
         endcase
         for (int i = 0; i < $urandom_range(1, 4); i++) run_scan(16'd0);
      end
      for (int i = 0; i < 3; i++) run_scan(16'd0);

      // Overflow: six distinct presses with no consumer.
      kif.key_ready = 1'b0;
      picks.delete();
      while (picks.size() < 6) begin
         idx = $urandom_range(0, 15);
         if (!(idx inside {picks})) picks.push_back(idx);
      end
      foreach (picks[i]) press(picks[i], 3, 3);
      chk("ovf_set", 16'(overflow), 16'd1);
      @(negedge clk); clr_ovf = 1'b1;
      @(negedge clk); clr_ovf = 1'b0; m_ovf = 0;
      chk("ovf_clr", 16'(overflow), 16'd0);
      while (exp_q.size() > 0) begin
         chk("drain_valid", 16'(kif.key_valid), 16'd1);
         chk("drain_code", 16'(kif.key_code), 16'(exp_q[0]));
         $display("pop code=%0h expected=%0h", kif.key_code, exp_q[0]);
         kif.key_ready = 1'b1;
         @(negedge clk);
         kif.key_ready = 1'b0;
         void'(exp_q.pop_front());
      end
      chk("drain_empty", 16'(kif.key_valid), 16'd0);

      // Reset mid-DRIVE of column 2 with two buffered events.
      do_reset();
      kif.key_ready = 1'b0;
      press(1, 3, 3);
      press(14, 3, 3);
      chk("pre_rst_valid", 16'(kif.key_valid), 16'd1);
      n = 0;
      while (col != 4'b1011 && n < 100) begin @(negedge clk); n++; end
      chk("reach_col2", 16'(col), 16'hB);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 16'(kif.key_valid), 16'd0);
      chk("arst_ovf", 16'(overflow), 16'd0);
      chk("arst_col", 16'(col), 16'hE);
      $display("async reset col=%b valid=%0b", col, kif.key_valid);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (col == 4'b1110) n++;
         else break;
      end
      chk("restart_hold", 16'(n), 16'd9);
      chk("restart_next", 16'(col), 16'hD);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
